// File: rtl/leaf_merge_arbiter.sv
// 2:1 packet-level merge arbiter, round-robin, grant held from header to tail flit.
// Latency: 1 cycle from accepted flit to out_valid (buffer empty); 1-cycle bubble per grant.
// Backpressure: 2-entry output buffer; granted port's ready = !full, from registered state only.
module leaf_merge_arbiter #(
   parameter int W        = 9,
   parameter int TAIL_BIT = 8,
   parameter int DEPTH    = 2
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [W-1:0] in0_data,
   input  logic         in0_valid,
   output logic         in0_ready,
   input  logic [W-1:0] in1_data,
   input  logic         in1_valid,
   output logic         in1_ready,
   output logic [W-1:0] out_data,
   output logic         out_sel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOCK0 = 2'd1;
   localparam logic [1:0] LOCK1 = 2'd2;

   logic [1:0]   state;
   logic         ptr;

   // two-slot circular buffer holding {sel, flit}
   logic [W-1:0] buf_dat [2];
   logic         buf_sel [2];
   logic         rd_idx;
   logic         wr_idx;
   logic [1:0]   count;

   logic         full;
   logic         empty;
   logic         wr0;
   logic         wr1;
   logic         wr;
   logic         rd;
   logic [W-1:0] wr_dat;

   assign full      = (count == 2'(DEPTH));
   assign empty     = (count == 2'd0);

   // readiness comes only from the grant state and the buffer fill level,
   // so out_ready never reaches the input handshake combinationally
   assign in0_ready = (state == LOCK0) && !full;
   assign in1_ready = (state == LOCK1) && !full;

   assign wr0       = in0_valid && in0_ready;
   assign wr1       = in1_valid && in1_ready;
   assign wr        = wr0 || wr1;
   assign wr_dat    = wr1 ? in1_data : in0_data;
   assign rd        = !empty && out_ready;

   assign out_valid = !empty;
   assign out_data  = buf_dat[rd_idx];
   assign out_sel   = buf_sel[rd_idx];
   assign busy      = (state != IDLE);

   // grant FSM: pick a port when idle, release it on the tail transfer
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         ptr   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in0_valid && (!in1_valid || !ptr))
                  state <= LOCK0;
               else if (in1_valid)
                  state <= LOCK1;
            end
            LOCK0: begin
               if (wr0 && in0_data[TAIL_BIT]) begin
                  state <= IDLE;
                  ptr   <= 1'b1;
               end
            end
            LOCK1: begin
               if (wr1 && in1_data[TAIL_BIT]) begin
                  state <= IDLE;
                  ptr   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // output buffer: write accepted flit with its source tag, pop on consumer handshake
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 2; i++) begin
            buf_dat[i] <= '0;
            buf_sel[i] <= 1'b0;
         end
         rd_idx <= 1'b0;
         wr_idx <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr) begin
            buf_dat[wr_idx] <= wr_dat;
            buf_sel[wr_idx] <= wr1;
            wr_idx          <= ~wr_idx;
         end
         if (rd)
            rd_idx <= ~rd_idx;
         case ({wr, rd})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_leaf_merge_arbiter.sv
// Bench for leaf_merge_arbiter: directed scenarios plus randomized traffic.
// Every cycle the DUT outputs are compared with a packet/queue-level reference model.
// Output backpressure is exercised both directed and randomly.
module tb_leaf_merge_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [8:0] in0_data, in1_data, out_data;
   logic       in0_valid, in0_ready, in1_valid, in1_ready;
   logic       out_sel, out_valid, out_ready, busy;

   always #5 CLK = ~CLK;

   leaf_merge_arbiter #(.W(9), .TAIL_BIT(8), .DEPTH(2)) dut (
      .CLK(CLK), .RESET(RESET),
      .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
      .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
      .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model: who owns the output (-1 none), next-preferred port, buffered flits
   int         owner;
   bit         mptr;
   logic [9:0] q[$];

   // observed output handshakes {sel, data} and the cycle they happened in
   logic [9:0] obs[$];
   int         obs_cyc[$];
   bit         acc0, acc1;

   // random packet sources
   int         g_len[2];
   int         g_idx[2];
   bit         g_on[2];
   logic [8:0] g_dat[2];
   bit         drain;

   logic [8:0] t1[3] = '{9'h012, 9'h034, 9'h156};
   logic [8:0] f4[4] = '{9'h021, 9'h022, 9'h023, 9'h124};

   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk10(input string tag, input logic [9:0] got, input logic [9:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      owner = -1;
      mptr  = 1'b0;
      q.delete();
   endtask

   // one clock cycle: compare at the falling edge, advance the model, return just after the rising edge
   task automatic step();
      bit rd;
      @(negedge CLK);
      chk1("busy", busy, owner != -1);
      chk1("in0_ready", in0_ready, (owner == 0) && (q.size() < 2));
      chk1("in1_ready", in1_ready, (owner == 1) && (q.size() < 2));
      chk1("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0)
         chk10("out_flit", {out_sel, out_data}, q[0]);
      acc0 = in0_valid && (owner == 0) && (q.size() < 2);
      acc1 = in1_valid && (owner == 1) && (q.size() < 2);
      rd   = (q.size() > 0) && out_ready;
      if (rd) begin
         obs.push_back({out_sel, out_data});
         obs_cyc.push_back(cyc);
         void'(q.pop_front());
      end
      if (acc0) q.push_back({1'b0, in0_data});
      else if (acc1) q.push_back({1'b1, in1_data});
      if (owner < 0) begin
         if (in0_valid && in1_valid) owner = mptr ? 1 : 0;
         else if (in0_valid) owner = 0;
         else if (in1_valid) owner = 1;
      end else if ((acc0 && in0_data[8]) || (acc1 && in1_data[8])) begin
         mptr  = (owner == 0);
         owner = -1;
      end
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b1;
      repeat (n) step();
   endtask

   // drive one flit on port p and hold it until the model says it was taken
   task automatic send(input int p, input logic [8:0] d);
      bit took;
      took = 1'b0;
      if (p == 0) begin in0_valid = 1'b1; in0_data = d; end
      else        begin in1_valid = 1'b1; in1_data = d; end
      for (int i = 0; i < 50 && !took; i++) begin
         step();
         took = (p == 0) ? acc0 : acc1;
      end
      chk1("send_accept", took, 1'b1);
   endtask

   task automatic gen_drive(input int pv, input int flen);
      logic t;
      for (int p = 0; p < 2; p++) begin
         if (!g_on[p] && ((g_idx[p] != 0 && (drain || $urandom_range(99) < pv)) ||
                          (g_idx[p] == 0 && !drain && $urandom_range(99) < pv))) begin
            if (g_idx[p] == 0) g_len[p] = (flen > 0) ? flen : $urandom_range(1, 4);
            t        = (g_idx[p] == g_len[p] - 1);
            g_dat[p] = {t, 8'($urandom)};
            g_on[p]  = 1'b1;
         end
      end
      in0_valid = g_on[0]; in0_data = g_dat[0];
      in1_valid = g_on[1]; in1_data = g_dat[1];
   endtask

   task automatic gen_after();
      if (acc0) begin g_on[0] = 1'b0; g_idx[0]++; if (g_idx[0] == g_len[0]) g_idx[0] = 0; end
      if (acc1) begin g_on[1] = 1'b0; g_idx[1]++; if (g_idx[1] == g_len[1]) g_idx[1] = 0; end
   endtask

   task automatic run_gen(input int ncyc, input int pv, input int po, input int flen);
      bit done;
      drain = 1'b0;
      repeat (ncyc) begin
         gen_drive(pv, flen);
         out_ready = ($urandom_range(99) < po);
         step();
         gen_after();
      end
      drain = 1'b1;
      done  = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         gen_drive(100, flen);
         out_ready = 1'b1;
         step();
         gen_after();
         done = (g_idx[0] == 0) && (g_idx[1] == 0) && !g_on[0] && !g_on[1];
      end
      chk1("gen_drain_done", done, 1'b1);
      drain = 1'b0;
      idle(4);
   endtask

   initial begin
      int s, c0, k, stall, cnt1;
      logic psel, in_pkt, first;

      RESET = 1'b1;
      in0_valid = 1'b0; in1_valid = 1'b0;
      in0_data = '0; in1_data = '0;
      out_ready = 1'b0;
      g_idx = '{0, 0}; g_on = '{0, 0}; g_len = '{1, 1};
      g_dat = '{9'h0, 9'h0}; drain = 1'b0;
      model_reset();
      #7;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk10("rst_out", {out_sel, out_data}, 10'h000);
      chk1("rst_in0_ready", in0_ready, 1'b0);
      chk1("rst_in1_ready", in1_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      @(posedge CLK); #1;
      RESET = 1'b0;

      // 1: three-flit packet from port 0, latency and back-to-back delivery
      out_ready = 1'b1;
      s  = obs.size();
      c0 = cyc;
      for (int i = 0; i < 3; i++) send(0, t1[i]);
      idle(4);
      chk10("t1_count", 10'(obs.size() - s), 10'd3);
      if (obs.size() - s >= 3) begin
         for (int i = 0; i < 3; i++) chk10("t1_flit", obs[s+i], {1'b0, t1[i]});
         chk10("t1_latency", 10'(obs_cyc[s] - c0), 10'd2);
         chk10("t1_contig", 10'(obs_cyc[s+2] - obs_cyc[s]), 10'd2);
      end
      chk1("t1_busy_end", busy, 1'b0);

      // 2: both ports stream 2-flit packets; grants alternate starting at port 1
      s = obs.size();
      run_gen(40, 100, 100, 2);
      first = 1'b1; in_pkt = 1'b0; psel = 1'b0;
      for (int i = s; i < obs.size(); i++) begin
         if (in_pkt) chk1("t2_pkt_sel", obs[i][9], psel);
         else begin
            if (first) chk1("t2_first_sel", obs[i][9], 1'b1);
            else       chk1("t2_alternate", obs[i][9], ~psel);
            first = 1'b0;
            psel  = obs[i][9];
         end
         in_pkt = !obs[i][8];
      end
      chk1("t2_saw_traffic", obs.size() - s >= 16, 1'b1);

      // 3: single-flit packet on port 1
      s = obs.size();
      in1_valid = 1'b1; in1_data = 9'h1FF;
      cnt1 = 0;
      step(); if (acc1) cnt1++;
      step(); if (acc1) cnt1++;
      in1_valid = 1'b0;
      chk1("t3_busy_after", busy, 1'b0);
      idle(3);
      chk10("t3_transfers", 10'(cnt1), 10'd1);
      chk10("t3_count", 10'(obs.size() - s), 10'd1);
      if (obs.size() > s) chk10("t3_flit", obs[s], 10'h3FF);

      // 4: output stalled for 5 cycles mid-packet
      s = obs.size(); k = 0; stall = 0;
      for (int c = 0; c < 30; c++) begin
         in0_valid = (k < 4);
         in0_data  = f4[(k < 4) ? k : 3];
         out_ready = !(k >= 1 && stall < 5);
         step();
         if (!out_ready) begin
            stall++;
            if (stall == 5) chk1("t4_stall_ready", in0_ready, 1'b0);
         end
         if (acc0) k++;
      end
      idle(3);
      chk10("t4_count", 10'(obs.size() - s), 10'd4);
      if (obs.size() - s >= 4)
         for (int i = 0; i < 4; i++) chk10("t4_flit", obs[s+i], {1'b0, f4[i]});

      // 5: port 0 pauses mid-packet while port 1 waits
      send(0, 9'h031);
      in0_valid = 1'b0;
      in1_valid = 1'b1; in1_data = 9'h1E0;
      repeat (3) begin
         step();
         chk1("t5_in1_held", in1_ready, 1'b0);
      end
      send(0, 9'h032);
      send(0, 9'h133);
      in0_valid = 1'b0;
      send(1, 9'h1E0);
      idle(4);

      // 6: asynchronous reset with the buffer full mid-packet
      out_ready = 1'b0;
      send(0, 9'h0A1);
      send(0, 9'h0A2);
      in0_data = 9'h0A3;
      step(); step();
      chk1("t6_full_ready", in0_ready, 1'b0);
      #1 RESET = 1'b1;
      #1;
      chk1("t6_out_valid", out_valid, 1'b0);
      chk1("t6_busy", busy, 1'b0);
      chk1("t6_in0_ready", in0_ready, 1'b0);
      chk10("t6_out", {out_sel, out_data}, 10'h000);
      model_reset();
      in0_valid = 1'b0;
      #1 RESET = 1'b0;
      out_ready = 1'b1;
      s = obs.size();
      send(1, 9'h0B1);
      send(1, 9'h1B2);
      in1_valid = 1'b0;
      idle(4);
      chk10("t6_count", 10'(obs.size() - s), 10'd2);
      if (obs.size() - s >= 2) begin
         chk10("t6_flit0", obs[s],   10'h2B1);
         chk10("t6_flit1", obs[s+1], 10'h3B2);
      end

      // 7: randomized traffic with random gaps and backpressure
      run_gen(3000, 60, 70, 0);
      run_gen(800, 90, 30, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
